fwd_hazard_scoreboard: RTL
==========================

Name: fwd_hazard_scoreboard

Overview:
- Parametrised decode-stage forwarding and hazard unit; successor to the fixed two-operand, two-stage ID forwarding logic.
- Keeps its own shadow pipeline of in-flight destination registers, NSTAGES deep.
- Per read port, outputs a forwarding-source select, or a stall when the youngest matching producer has no result yet (load-use, multi-cycle ops).
- Sits beside the ID stage; drives the operand bypass muxes and the ID/EX bubble insertion.

Parameters:
- NPORTS, 2, number of decode read ports (rs, rt, ...).
- NSTAGES, 3, tracked post-decode stages; index 0 = EX, 1 = MEM, 2 = WB.
- AW, 5, register address width.
- RSW, 2, width of the ready-stage field; must satisfy 2^RSW >= NSTAGES.
- SELW, 2, width of each forward select; must satisfy 2^SELW >= NSTAGES+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction present in ID.
- issue_we  in  1  that instruction writes a register.
- issue_waddr  in  AW  its destination register.
- issue_rdy_stage  in  RSW  first stage index whose output carries the result (0 = ALU, 1 = load).
- rd_addr  in  NPORTS*AW  source addresses; port p occupies bits [p*AW +: AW].
- rd_used  in  NPORTS  port p is actually read.
- flush  in  1  squash the ID instruction (taken branch / exception).
- stall_ext  in  1  whole pipeline frozen (cache miss).
- fw_sel  out  NPORTS*SELW  per port: 0 = register file, k = forward from stage k-1.
- stall_d  out  1  hold IF/ID and insert a bubble into EX.
- issue_accept  out  1  the ID instruction enters the shadow pipeline this cycle.

Behaviour:
- State: NSTAGES entries, each holding {vld, we, waddr, rdy}. Entry 0 = EX.
- Reset: all vld cleared asynchronously. fw_sel = 0, stall_d = 0, issue_accept = 0 while rst_n is low and in the cycle after release.
- Per entry: match_i,p = vld & we & (waddr != 0) & (waddr == rd_addr[p]) & rd_used[p].
- Per port: j = lowest i with match_i,p (youngest producer wins).
  - No match: fw_sel[p] = 0.
  - j >= rdy_j: fw_sel[p] = j+1.
  - Otherwise: fw_sel[p] = 0 and port p hazards.
- stall_d = OR of port hazards. Purely combinational from the entries and the current inputs; zero-cycle latency.
- issue_accept = issue_valid & !stall_d & !stall_ext & !flush.
- Clock edge, stall_ext = 1: all entries hold. This has priority over flush and stall_d.
- Clock edge, stall_ext = 0: entry i+1 <= entry i; the oldest entry is discarded.
  - Entry 0 <= {1, issue_we, issue_waddr, issue_rdy_stage} if issue_accept.
  - Entry 0 <= bubble (vld = 0) otherwise.
- A hazard therefore clears after exactly (rdy - j) stall cycles, because the producer advances while bubbles are inserted.
- rdy values >= NSTAGES never become forwardable. The unit stalls until the producer retires, after which the register file supplies the value. Integration must guarantee this is legal.
- Address 0 never matches; fw_sel = 0.
- flush and stall_d in the same cycle: bubble into entry 0, no accept.
- Reset mid-operation: all in-flight entries drop immediately.
- stall_d is independent of issue_valid. The integrator masks it with issue_valid.

Optional Feature:
- FWD_STATS_EN defined:
  - Adds output stat_stall_cnt (16 bits), counting cycles with stall_d & !stall_ext.
  - Adds output stat_fwd_cnt (16 bits), counting cycles where issue_accept = 1 and any fw_sel != 0.
  - Both counters saturate at 0xFFFF and clear on reset.
- FWD_STATS_EN undefined: neither port exists and there is no counter logic.

Test Plan:
- ALU producer, back-to-back consumer: issue we=1, waddr=8, rdy=0. Next cycle rd_addr[0]=8, rd_used=1. Expect fw_sel[0]=1, stall_d=0. One cycle later expect fw_sel[0]=2; one cycle after that, fw_sel[0]=3.
- Load-use: issue waddr=9, rdy=1, then a consumer of r9 on port 1. Expect stall_d=1 for exactly 1 cycle, then fw_sel[1]=2 with issue_accept=1.
- Priority: r5 written by back-to-back issues A then B, then a consumer of r5. Expect fw_sel=1 (B), not 2.
- r0 and rd_used gating:
  - Producer waddr=0, consumer of r0: fw_sel=0, no stall.
  - Producer waddr=4 (rdy=1, load) with rd_used=0 on the matching port: fw_sel=0, stall_d=0.
- stall_ext during a load-use stall: assert stall_ext for 3 cycles. Entries frozen, stall_d stays 1. Release stall_ext; stall_d clears 1 cycle later.
- flush: issue waddr=7 with flush=1. issue_accept=0, and a following consumer of r7 gets fw_sel=0. Then assert rst_n=0 mid-stream: all fw_sel=0 and stall_d=0 immediately.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard
//
// Decode-stage forwarding and hazard unit. Tracks the destination registers
// of the NSTAGES instructions that have left ID in a shadow pipeline
// (entry 0 = EX, 1 = MEM, 2 = WB). For every read port it picks a bypass
// source, or raises stall_d when the youngest matching producer has not
// produced its result yet.
//
// Optional build macro: FWD_STATS_EN adds two saturating 16-bit statistics
// counters (stall cycles, forwarded issues).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   issue_valid       instruction present in ID
//   issue_we          that instruction writes a register
//   issue_waddr       its destination register
//   issue_rdy_stage   first stage index whose output carries the result
//   rd_addr           source addresses, port p at [p*AW +: AW]
//   rd_used           port p is actually read
//   flush             squash the ID instruction
//   stall_ext         freeze the whole pipeline
//   fw_sel            per port: 0 = register file, k = forward from stage k-1
//   stall_d           hold IF/ID, insert a bubble into EX
//   issue_accept      ID instruction enters the shadow pipeline this cycle
//   stat_stall_cnt    (FWD_STATS_EN) cycles with stall_d & !stall_ext
//   stat_fwd_cnt      (FWD_STATS_EN) accepted issues using any forward
//
// Handshake: issue_valid is the offer from ID; issue_accept is the
// acknowledgement. An instruction is captured into entry 0 on the clock edge
// of the cycle in which issue_accept is high, and only then.
// ---------------------------------------------------------------------------
module fwd_hazard_scoreboard #(
    parameter int NPORTS  = 2,
    parameter int NSTAGES = 3,
    parameter int AW      = 5,
    parameter int RSW     = 2,
    parameter int SELW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic                   issue_we,
    input  logic [AW-1:0]          issue_waddr,
    input  logic [RSW-1:0]         issue_rdy_stage,
    input  logic [NPORTS*AW-1:0]   rd_addr,
    input  logic [NPORTS-1:0]      rd_used,
    input  logic                   flush,
    input  logic                   stall_ext,
    output logic [NPORTS*SELW-1:0] fw_sel,
    output logic                   stall_d,
    output logic                   issue_accept
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]            stat_stall_cnt,
    output logic [15:0]            stat_fwd_cnt
`endif
);

    // Shadow pipeline entries
    logic [NSTAGES-1:0] entVld;
    logic [NSTAGES-1:0] entWe;
    logic [AW-1:0]      entAddr [NSTAGES];
    logic [RSW-1:0]     entRdy  [NSTAGES];

    // Low during reset and for the first cycle after release, so nothing is
    // accepted until the pipeline around us has come out of reset as well.
    logic rstDone;

    logic [NPORTS-1:0] portHazard;

    // -----------------------------------------------------------------------
    // Match / select. Stages are scanned oldest to youngest so the youngest
    // matching producer overwrites any older one.
    // -----------------------------------------------------------------------
    always_comb begin
        logic            hit;
        logic            fwdOk;
        logic [SELW-1:0] sel;
        fw_sel     = '0;
        portHazard = '0;
        for (int p = 0; p < NPORTS; p++) begin
            hit   = 1'b0;
            fwdOk = 1'b0;
            sel   = '0;
            for (int i = NSTAGES - 1; i >= 0; i--) begin
                if (entVld[i] && entWe[i] && (entAddr[i] != '0) &&
                    (entAddr[i] == rd_addr[p*AW +: AW]) && rd_used[p]) begin
                    hit   = 1'b1;
                    // Result exists once the producer sits at or beyond its
                    // ready stage; rdy >= NSTAGES therefore never forwards.
                    fwdOk = (i >= int'(entRdy[i]));
                    sel   = SELW'(i + 1);
                end
            end
            if (hit && fwdOk) begin
                fw_sel[p*SELW +: SELW] = sel;
            end else if (hit) begin
                portHazard[p] = 1'b1;
            end
        end
    end

    assign stall_d      = |portHazard;
    assign issue_accept = rstDone & issue_valid & ~stall_d & ~stall_ext & ~flush;

    // -----------------------------------------------------------------------
    // Shadow pipeline. stall_ext freezes everything; otherwise the entries
    // shift one stage and entry 0 takes the accepted instruction or a bubble.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstDone <= 1'b0;
            entVld  <= '0;
            entWe   <= '0;
            for (int i = 0; i < NSTAGES; i++) begin
                entAddr[i] <= '0;
                entRdy[i]  <= '0;
            end
        end else begin
            rstDone <= 1'b1;
            if (!stall_ext) begin
                for (int i = NSTAGES - 1; i >= 1; i--) begin
                    entVld[i]  <= entVld[i-1];
                    entWe[i]   <= entWe[i-1];
                    entAddr[i] <= entAddr[i-1];
                    entRdy[i]  <= entRdy[i-1];
                end
                // Payload is loaded unconditionally; vld alone marks a bubble.
                entVld[0]  <= issue_accept;
                entWe[0]   <= issue_we;
                entAddr[0] <= issue_waddr;
                entRdy[0]  <= issue_rdy_stage;
            end
        end
    end

`ifdef FWD_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating statistics counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            if (stall_d && !stall_ext && (stat_stall_cnt != 16'hFFFF)) begin
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            end
            if (issue_accept && (|fw_sel) && (stat_fwd_cnt != 16'hFFFF)) begin
                stat_fwd_cnt <= stat_fwd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
